// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction prefetch stage between the shared RAM read port and decode.
//   It issues sequential word addresses to a RAM with a fixed 1-cycle read
//   latency and buffers each returned word with its address in a small FIFO.
//   The FIFO head is offered to decode over a valid/ready handshake. A flush
//   (redirect) drops all buffered and in-flight words and restarts fetching
//   at flush_pc.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous, active-low reset
//   mem_rd_en    RAM read request this cycle
//   mem_addr     RAM read address (the current fetch pc)
//   mem_rdata    RAM data, valid the cycle after mem_rd_en=1
//   instr        FIFO head instruction word
//   instr_pc     address of instr
//   instr_valid  head valid
//   instr_ready  decode accepts the head
//   flush        redirect request, single- or multi-cycle
//   flush_pc     new fetch address, sampled while flush=1
module ifetch_queue #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] word_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  inflight;
  logic                  inflight_kill;
  logic [ADDR_WIDTH-1:0] inflight_addr;
  logic [DATA_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0] hold_pc;

  logic [CNT_W-1:0]      occupancy;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  // Occupancy counts the word still in flight so a request is only issued
  // when there is guaranteed room for its response. The pre-pop count is
  // used on purpose, so a full FIFO being popped does not request that cycle.
  // mem_rd_en is gated by rst so it stays low while reset is held.
  always_comb begin
    occupancy   = count + CNT_W'(inflight);
    fifo_empty  = (count == '0);
    mem_rd_en   = rst && !flush && (occupancy < DEPTH_CNT);
    mem_addr    = pc;
    instr_valid = !fifo_empty && !flush;
    push        = inflight && !inflight_kill && !flush;
    pop         = instr_valid && instr_ready;
    // When the FIFO drains, the head outputs keep showing the last head.
    instr       = fifo_empty ? hold_instr : word_mem[rd_ptr];
    instr_pc    = fifo_empty ? hold_pc    : addr_mem[rd_ptr];
  end

  // Fetch pc, in-flight tracking and FIFO pointers/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_kill <= 1'b0;
      inflight_addr <= '0;
    end else if (flush) begin
      pc            <= flush_pc;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_kill <= inflight;
    end else begin
      inflight      <= mem_rd_en;
      inflight_kill <= 1'b0;
      if (mem_rd_en) begin
        pc            <= pc + ADDR_WIDTH'(1);
        inflight_addr <= pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared by reset so the head outputs read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (push) begin
      word_mem[wr_ptr] <= mem_rdata;
      addr_mem[wr_ptr] <= inflight_addr;
    end
  end

  // Snapshot of the displayed head, used once the FIFO goes empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (!fifo_empty) begin
      hold_instr <= word_mem[rd_ptr];
      hold_pc    <= addr_mem[rd_ptr];
    end
  end

endmodule
